// File: rtl/reg_wr_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_wr_seq_pkg                                            |
// | Purpose  : Shared state encoding and constants for the register-bank  |
// |            write sequencer.                                          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package reg_wr_seq_pkg;

  // Sequencer modes: normal issue, finishing queued writes, zero sweep
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Value written to every register during a clear-all sweep
  localparam logic [7:0] c_clr_data = 8'h00;

endpackage
`default_nettype wire

// File: rtl/reg_wr_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_wr_seq_if                                             |
// | Purpose  : Request handshake, clear command and bank write port of    |
// |            the write sequencer, bundled for port connection.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface reg_wr_seq_if #(
  parameter int ADDR_W = 3
);
  import reg_wr_seq_pkg::*;

  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic [7:0]        i_req_data;
  logic              o_req_ready;
  logic              i_clr;
  logic              o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [7:0]        o_data;
  logic              o_busy;
  logic              o_clr_done;

  // Upstream decode / bench side
  modport master (
    output i_req_valid, i_req_addr, i_req_data, i_clr,
    input  o_req_ready, o_we, o_addr, o_data, o_busy, o_clr_done
  );

  // Sequencer side
  modport slave (
    input  i_req_valid, i_req_addr, i_req_data, i_clr,
    output o_req_ready, o_we, o_addr, o_data, o_busy, o_clr_done
  );

endinterface
`default_nettype wire

// File: rtl/reg_wr_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_wr_fifo                                               |
// | Purpose  : Small synchronous FIFO holding pending {addr,data} writes. |
// |            Head is visible combinationally; no bypass.               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module reg_wr_fifo
  import reg_wr_seq_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  wire logic                   i_clk,
  input  wire logic                   i_reset,
  input  wire logic                   i_push,
  input  wire logic [WIDTH-1:0]       i_data,
  input  wire logic                   i_pop,
  output logic      [WIDTH-1:0]       o_data,
  output logic      [$clog2(DEPTH):0] o_count,
  output logic                        o_full,
  output logic                        o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == c_depth);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  // Overflow/underflow requests are dropped rather than corrupting state
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array; contents need no reset since pointers define validity
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap at DEPTH naturally
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_wr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_wr_seq                                                |
// | Purpose  : Write-side sequencer for the 8-bit register bank. Queues   |
// |            upstream writes, issues one per cycle and runs a clear-all |
// |            sweep writing zero to every register.                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module reg_wr_seq
  import reg_wr_seq_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8,
  parameter int DEPTH  = 4
) (
  input  wire logic    i_clk,
  input  wire logic    i_reset,
  reg_wr_seq_if.slave  bus
);

  localparam int DW = ADDR_W + 8;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NREGS - 1);
  localparam logic [CW-1:0]     c_one      = CW'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_sweep_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_clr_done;

  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic [DW-1:0]     w_head;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;

  // New requests only while idle, so a pending sweep cannot be overtaken
  assign w_ready = !w_full && (r_state == ST_IDLE);
  assign w_push  = bus.i_req_valid && w_ready;
  assign w_pop   = !w_empty && (r_state != ST_CLEAR);

  reg_wr_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  ({bus.i_req_addr, bus.i_req_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Mode control, sweep index and registered bank write port
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_sweep_last <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_clr_done   <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_clr_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DRAIN: begin
          if (w_pop) begin
            r_we   <= 1'b1;
            r_addr <= w_head[DW-1:8];
            r_data <= w_head[7:0];
          end
          if (r_state == ST_DRAIN) begin
            // The entry popped on this edge is the last one queued
            if (w_count <= c_one) begin
              r_state      <= ST_CLEAR;
              r_idx        <= '0;
              r_sweep_last <= 1'b0;
            end
          end else if (bus.i_clr) begin
            // A request accepted alongside the clear is written first
            if (w_empty && !w_push) begin
              r_state      <= ST_CLEAR;
              r_idx        <= '0;
              r_sweep_last <= 1'b0;
            end else begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_CLEAR: begin
          if (r_sweep_last) begin
            r_clr_done   <= 1'b1;
            r_sweep_last <= 1'b0;
            r_idx        <= '0;
            r_state      <= ST_IDLE;
          end else begin
            r_we   <= 1'b1;
            r_addr <= r_idx;
            r_data <= c_clr_data;
            // idx stops at the last register; a flag marks the final write
            if (r_idx == c_last_idx) begin
              r_sweep_last <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = w_ready;
  assign bus.o_busy      = !w_empty || (r_state != ST_IDLE) || r_we;
  assign bus.o_we        = r_we;
  assign bus.o_addr      = r_addr;
  assign bus.o_data      = r_data;
  assign bus.o_clr_done  = r_clr_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_wr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_reg_wr_seq                                             |
// | Purpose  : Self-checking bench for reg_wr_seq against a queue-based   |
// |            reference model of the write stream and clear sweep.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_reg_wr_seq;

  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst_n;

  reg_wr_seq_if #(.ADDR_W(ADDR_W)) bus ();

  reg_wr_seq #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Overall time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its end (got running, need finished)");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending writes queue, mode 0=normal 1=clear pending 2=sweeping
  logic [ADDR_W+7:0] q[$];
  int                mode;
  int                sweep_n;
  int                n_acc;
  logic              e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [7:0]        e_data;
  logic              e_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode    = 0;
    sweep_n = 0;
    e_we    = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    e_done  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge and compare
  task automatic step(input logic v, input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic c);
    logic m_ready;
    logic acc;
    int   old_size;
    bus.i_req_valid = v;
    bus.i_req_addr  = a;
    bus.i_req_data  = d;
    bus.i_clr       = c;
    old_size = q.size();
    m_ready  = (old_size < DEPTH) && (mode == 0);
    chk("ready", bus.o_req_ready, m_ready);
    chk("busy", bus.o_busy, (old_size > 0) || (mode != 0) || e_we);
    acc    = v && m_ready;
    e_done = 1'b0;
    if (mode == 2) begin
      if (sweep_n < NREGS) begin
        e_we   = 1'b1;
        e_addr = ADDR_W'(sweep_n);
        e_data = 8'h00;
        sweep_n++;
      end else begin
        e_we   = 1'b0;
        e_done = 1'b1;
        mode   = 0;
      end
    end else begin
      if (old_size > 0) begin
        e_we = 1'b1;
        {e_addr, e_data} = q.pop_front();
      end else begin
        e_we = 1'b0;
      end
      if (mode == 1) begin
        if (old_size <= 1) begin
          mode    = 2;
          sweep_n = 0;
        end
      end else if (c) begin
        if (old_size == 0 && !acc) begin
          mode    = 2;
          sweep_n = 0;
        end else begin
          mode = 1;
        end
      end
    end
    if (acc) begin
      q.push_back({a, d});
      n_acc++;
    end
    @(posedge clk);
    #1;
    chk("we", bus.o_we, e_we);
    chk("addr", bus.o_addr, e_addr);
    chk("data", bus.o_data, e_data);
    chk("clr_done", bus.o_clr_done, e_done);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 8'h00, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", bus.o_we, 0);
    chk("rst_addr", bus.o_addr, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_done", bus.o_clr_done, 0);
    chk("rst_busy", bus.o_busy, 0);
    rst_n = 1'b1;
    chk("rel_ready", bus.o_req_ready, 1);
  endtask

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = '0;
    bus.i_req_data  = '0;
    bus.i_clr       = 1'b0;
    n_acc           = 0;
    apply_reset();

    // Single write
    step(1'b1, 3'd3, 8'hF0, 1'b0);
    idle(4);

    // Back-to-back burst
    step(1'b1, 3'd1, 8'h11, 1'b0);
    step(1'b1, 3'd2, 8'h22, 1'b0);
    step(1'b1, 3'd3, 8'h33, 1'b0);
    step(1'b1, 3'd4, 8'h44, 1'b0);
    step(1'b1, 3'd5, 8'h55, 1'b0);
    idle(4);

    // Clear issued alongside the third queued request
    step(1'b1, 3'd6, 8'hA1, 1'b0);
    step(1'b1, 3'd7, 8'hA2, 1'b0);
    step(1'b1, 3'd2, 8'hA3, 1'b1);
    idle(NREGS + 6);

    // Clear with empty queue, second clear mid-sweep is ignored
    step(1'b0, '0, 8'h00, 1'b1);
    idle(4);
    step(1'b0, '0, 8'h00, 1'b1);
    idle(NREGS + 4);

    // Reset mid-sweep once address 4 is on the bus
    step(1'b0, '0, 8'h00, 1'b1);
    for (int k = 0; k < 20 && !(mode == 2 && e_we && e_addr == 3'd4); k++) begin
      step(1'b0, '0, 8'h00, 1'b0);
    end
    chk("sweep_at_idx4_we", bus.o_we, 1);
    chk("sweep_at_idx4_addr", bus.o_addr, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_we", bus.o_we, 0);
    chk("async_addr", bus.o_addr, 0);
    chk("async_data", bus.o_data, 0);
    chk("async_done", bus.o_clr_done, 0);
    chk("async_ready", bus.o_req_ready, 1);
    apply_reset();
    idle(NREGS + 4);

    // Randomized traffic with occasional clears
    n_acc = 0;
    for (int k = 0; k < 3000 && n_acc < 200; k++) begin
      step(($urandom_range(0, 9) < 7), ADDR_W'($urandom), 8'($urandom),
           ($urandom_range(0, 49) == 0));
    end
    chk("random_accepted", n_acc, 200);
    idle(NREGS + 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
